// File: rtl/ff_conv_pkg.sv
// Shared types for the flip-flop conversion arbiter: operation modes and FSM states.
package ff_conv_pkg;

  // Conversion mode selected per requester; encoding matches the mode bus slices.
  typedef enum logic [1:0] {
    MODE_D  = 2'd0,
    MODE_T  = 2'd1,
    MODE_JK = 2'd2,
    MODE_SR = 2'd3
  } mode_e;

  // Sequencer states; one full operation visits each state once.
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_GRANT = 2'd1,
    ST_APPLY = 2'd2,
    ST_ACK   = 2'd3
  } state_e;

endpackage

// File: rtl/ff_conv_core.sv
// Combinational next-state for a WIDTH-bit register under D/T/JK/SR semantics.
// Operand a is D/T/J/S, operand b is K/R (ignored for D and T).
module ff_conv_core
  import ff_conv_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  mode_e             mode_i,
  input  logic [WIDTH-1:0]  a_i,
  input  logic [WIDTH-1:0]  b_i,
  input  logic [WIDTH-1:0]  q_i,
  output logic [WIDTH-1:0]  q_next_o,
  output logic              illegal_o
);

  logic [WIDTH-1:0] both_set;

  assign both_set = a_i & b_i;

  // Per-bit next-state equation; SR bits with S=R=1 keep their current value.
  always_comb begin
    q_next_o  = q_i;
    illegal_o = 1'b0;
    unique case (mode_i)
      MODE_D:  q_next_o = a_i;
      MODE_T:  q_next_o = q_i ^ a_i;
      MODE_JK: q_next_o = (a_i & ~q_i) | (~b_i & q_i);
      MODE_SR: begin
        q_next_o  = ((a_i | (~b_i & q_i)) & ~both_set) | (q_i & both_set);
        illegal_o = |both_set;
      end
      default: q_next_o = q_i;
    endcase
  end

endmodule

// File: rtl/ff_conv_arbiter.sv
// Round-robin sequencer sharing one WIDTH-bit state register among NREQ requesters.
// Each granted op walks IDLE -> GRANT -> APPLY -> ACK; operands are latched in GRANT
// so the winner may drop req early without losing its operation.
module ff_conv_arbiter
  import ff_conv_pkg::*;
#(
  parameter int NREQ  = 4,
  parameter int WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [NREQ-1:0]       req,
  input  logic [2*NREQ-1:0]     mode,
  input  logic [WIDTH*NREQ-1:0] a,
  input  logic [WIDTH*NREQ-1:0] b,
  output logic [WIDTH-1:0]      q,
  output logic [WIDTH-1:0]      qb,
  output logic [NREQ-1:0]       gnt,
  output logic [NREQ-1:0]       ack,
  output logic                  busy,
  output logic                  err
);

  localparam int IDX_W = (NREQ > 1) ? $clog2(NREQ) : 1;

  // Per-requester views of the flat operand buses.
  logic [NREQ-1:0][1:0]       mode_arr;
  logic [NREQ-1:0][WIDTH-1:0] a_arr;
  logic [NREQ-1:0][WIDTH-1:0] b_arr;

  assign mode_arr = mode;
  assign a_arr    = a;
  assign b_arr    = b;

  state_e            state_q, state_d;
  logic [IDX_W-1:0]  win_q, win_d;
  logic [IDX_W-1:0]  rr_ptr_q, rr_ptr_d;
  logic [WIDTH-1:0]  q_q, q_d;
  logic              err_q, err_d;
  mode_e             op_mode_q;
  logic [WIDTH-1:0]  op_a_q, op_b_q;
  logic [WIDTH-1:0]  q_next;
  logic              illegal;
  logic [IDX_W-1:0]  pick;
  logic [NREQ-1:0]   win_oh;

  // First asserted request at or after the pointer, wrapping past NREQ-1.
  function automatic logic [IDX_W-1:0] rr_pick(input logic [NREQ-1:0]  r,
                                               input logic [IDX_W-1:0] p);
    logic [IDX_W-1:0] sel;
    logic [IDX_W:0]   sum;
    logic             hit;
    sel = '0;
    hit = 1'b0;
    for (int k = 0; k < NREQ; k++) begin
      sum = {1'b0, p} + (IDX_W+1)'(k);
      if (sum >= (IDX_W+1)'(NREQ)) sum = sum - (IDX_W+1)'(NREQ);
      if (!hit && r[sum[IDX_W-1:0]]) begin
        hit = 1'b1;
        sel = sum[IDX_W-1:0];
      end
    end
    return sel;
  endfunction

  assign pick = rr_pick(req, rr_ptr_q);

  ff_conv_core #(.WIDTH(WIDTH)) u_core (
    .mode_i    (op_mode_q),
    .a_i       (op_a_q),
    .b_i       (op_b_q),
    .q_i       (q_q),
    .q_next_o  (q_next),
    .illegal_o (illegal)
  );

  // Next-state logic for the sequencer, winner, pointer, register and error flag.
  always_comb begin
    state_d  = state_q;
    win_d    = win_q;
    rr_ptr_d = rr_ptr_q;
    q_d      = q_q;
    err_d    = err_q;
    unique case (state_q)
      ST_IDLE: begin
        if (|req) begin
          win_d   = pick;
          state_d = ST_GRANT;
        end
      end
      ST_GRANT: state_d = ST_APPLY;
      ST_APPLY: begin
        q_d     = q_next;
        err_d   = illegal;
        state_d = ST_ACK;
      end
      ST_ACK: begin
        // Moving past the winner keeps a re-asserting requester behind everyone else.
        rr_ptr_d = (win_q == IDX_W'(NREQ-1)) ? '0 : win_q + 1'b1;
        state_d  = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Control and shared register state; reset discards any op in flight.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= ST_IDLE;
      win_q    <= '0;
      rr_ptr_q <= '0;
      q_q      <= '0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      win_q    <= win_d;
      rr_ptr_q <= rr_ptr_d;
      q_q      <= q_d;
      err_q    <= err_d;
    end
  end

  // Capture the winner's operands at the end of GRANT so later req/operand changes are ignored.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      op_mode_q <= MODE_D;
      op_a_q    <= '0;
      op_b_q    <= '0;
    end else if (state_q == ST_GRANT) begin
      op_mode_q <= mode_e'(mode_arr[win_q]);
      op_a_q    <= a_arr[win_q];
      op_b_q    <= b_arr[win_q];
    end
  end

  assign win_oh = NREQ'(1) << win_q;
  assign busy   = (state_q != ST_IDLE);
  assign gnt    = busy ? win_oh : '0;
  assign ack    = (state_q == ST_ACK) ? win_oh : '0;
  assign err    = (state_q == ST_ACK) && err_q;
  assign q      = q_q;
  assign qb     = ~q_q;

endmodule

// File: tb/tb_ff_conv_arbiter.sv
// Directed bench for ff_conv_arbiter: reset, each conversion mode, round-robin order,
// early req drop and mid-op reset, with hand-computed expected register values.
module tb_ff_conv_arbiter;

  localparam int NREQ  = 4;
  localparam int WIDTH = 8;
  localparam logic [1:0] M_D  = 2'd0;
  localparam logic [1:0] M_T  = 2'd1;
  localparam logic [1:0] M_JK = 2'd2;
  localparam logic [1:0] M_SR = 2'd3;

  logic                  clk;
  logic                  rst;
  logic [NREQ-1:0]       req;
  logic [2*NREQ-1:0]     mode;
  logic [WIDTH*NREQ-1:0] a;
  logic [WIDTH*NREQ-1:0] b;
  logic [WIDTH-1:0]      q;
  logic [WIDTH-1:0]      qb;
  logic [NREQ-1:0]       gnt;
  logic [NREQ-1:0]       ack;
  logic                  busy;
  logic                  err;

  int checks = 0;
  int errors = 0;

  ff_conv_arbiter #(.NREQ(NREQ), .WIDTH(WIDTH)) dut (
    .clk  (clk),
    .rst  (rst),
    .req  (req),
    .mode (mode),
    .a    (a),
    .b    (b),
    .q    (q),
    .qb   (qb),
    .gnt  (gnt),
    .ack  (ack),
    .busy (busy),
    .err  (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Issue one op on requester r and wait (bounded) for its ack; returns edges-to-ack,
  // err seen with ack, and gnt seen after the first edge.
  task automatic run_op(input int r, input logic [1:0] m, input logic [7:0] av,
                        input logic [7:0] bv, input bit drop_early,
                        output int lat, output logic errv, output logic [NREQ-1:0] g1);
    @(posedge clk); #1;
    mode[2*r +: 2] = m;
    a[8*r +: 8]    = av;
    b[8*r +: 8]    = bv;
    req[r]         = 1'b1;
    lat  = -1;
    errv = 1'b0;
    g1   = '0;
    for (int k = 1; k <= 12; k++) begin
      @(posedge clk); #1;
      if (k == 1) begin
        g1 = gnt;
        if (drop_early) req[r] = 1'b0;
      end
      if (ack[r]) begin
        lat  = k;
        errv = err;
        break;
      end
    end
    req[r] = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b0; req = '0; mode = '0; a = '0; b = '0;
    #12;
    checks++; if (q !== 8'h00) begin errors++; $display("FAIL reset_q: got %h expected 00", q); end
    checks++; if (qb !== 8'hFF) begin errors++; $display("FAIL reset_qb: got %h expected ff", qb); end
    checks++; if (gnt !== 4'h0 || ack !== 4'h0) begin errors++; $display("FAIL reset_gnt_ack: got %h/%h expected 0/0", gnt, ack); end
    checks++; if (busy !== 1'b0 || err !== 1'b0) begin errors++; $display("FAIL reset_busy_err: got %b/%b expected 0/0", busy, err); end
    #3 rst = 1'b1;
  endtask

  task automatic test_idle();
    for (int k = 0; k < 3; k++) begin
      @(posedge clk); #1;
      checks++;
      if (busy !== 1'b0 || gnt !== 4'h0 || q !== 8'h00) begin
        errors++; $display("FAIL idle_hold: busy %b gnt %h q %h expected 0 0 00", busy, gnt, q);
      end
    end
  endtask

  task automatic test_d_then_t();
    int lat; logic e; logic [NREQ-1:0] g;
    run_op(0, M_D, 8'hA5, 8'h00, 1'b0, lat, e, g);
    checks++; if (lat !== 3) begin errors++; $display("FAIL d_latency: got %0d expected 3", lat); end
    checks++; if (g !== 4'b0001) begin errors++; $display("FAIL d_gnt: got %b expected 0001", g); end
    checks++; if (q !== 8'hA5 || qb !== 8'h5A) begin errors++; $display("FAIL d_q: got %h/%h expected a5/5a", q, qb); end
    @(posedge clk); #1;
    checks++; if (ack !== 4'h0 || busy !== 1'b0) begin errors++; $display("FAIL ack_pulse: ack %h busy %b expected 0 0", ack, busy); end
    run_op(0, M_T, 8'h0F, 8'h00, 1'b0, lat, e, g);
    checks++; if (lat !== 3) begin errors++; $display("FAIL t_latency: got %0d expected 3", lat); end
    checks++; if (q !== 8'hAA) begin errors++; $display("FAIL t_q: got %h expected aa", q); end
  endtask

  // q=AA, J=F0, K=3C: bits 7,6 set-or-hold 1; 5,4 toggle; 3,2 reset; 1,0 hold -> D2.
  task automatic test_jk();
    int lat; logic e; logic [NREQ-1:0] g;
    run_op(1, M_JK, 8'hF0, 8'h3C, 1'b0, lat, e, g);
    checks++; if (lat !== 3 || g !== 4'b0010) begin errors++; $display("FAIL jk_lat_gnt: got %0d/%b expected 3/0010", lat, g); end
    checks++; if (q !== 8'hD2) begin errors++; $display("FAIL jk_q: got %h expected d2", q); end
    checks++; if (e !== 1'b0) begin errors++; $display("FAIL jk_err: got %b expected 0", e); end
  endtask

  task automatic test_sr_illegal();
    int lat; logic e; logic [NREQ-1:0] g;
    run_op(2, M_D, 8'h00, 8'h00, 1'b0, lat, e, g);
    checks++; if (q !== 8'h00) begin errors++; $display("FAIL sr_pre_q: got %h expected 00", q); end
    run_op(2, M_SR, 8'h03, 8'h01, 1'b0, lat, e, g);
    checks++; if (lat !== 3) begin errors++; $display("FAIL sr_latency: got %0d expected 3", lat); end
    checks++; if (q !== 8'h02) begin errors++; $display("FAIL sr_q: got %h expected 02", q); end
    checks++; if (e !== 1'b1) begin errors++; $display("FAIL sr_err: got %b expected 1", e); end
  endtask

  task automatic test_round_robin();
    int lat; logic e; logic [NREQ-1:0] g;
    int order[5]; int when[5]; logic [7:0] qs[5]; int n; int exp_idx;
    // Serving req3 wraps the pointer back to 0.
    run_op(3, M_D, 8'h00, 8'h00, 1'b0, lat, e, g);
    checks++; if (lat !== 3) begin errors++; $display("FAIL rr_wrap_lat: got %0d expected 3", lat); end
    @(posedge clk); #1;
    mode = '0;
    a    = {8'h13, 8'h12, 8'h11, 8'h10};
    req  = 4'hF;
    n = 0;
    for (int k = 1; k <= 40 && n < 5; k++) begin
      @(posedge clk); #1;
      if (|ack) begin
        order[n] = -1;
        for (int j = 0; j < NREQ; j++) if (ack[j]) order[n] = j;
        when[n] = k;
        qs[n]   = q;
        n++;
      end
    end
    req = '0;
    checks++; if (n !== 5) begin errors++; $display("FAIL rr_count: got %0d acks expected 5", n); end
    for (int i = 0; i < n; i++) begin
      exp_idx = i % NREQ;
      checks++;
      if (order[i] !== exp_idx || when[i] !== 3 + 4*i || qs[i] !== 8'h10 + 8'(exp_idx)) begin
        errors++;
        $display("FAIL rr_slot%0d: got req%0d at %0d q %h expected req%0d at %0d q %h",
                 i, order[i], when[i], qs[i], exp_idx, 3 + 4*i, 8'h10 + 8'(exp_idx));
      end
    end
    run_op(3, M_D, 8'h5A, 8'h00, 1'b0, lat, e, g);
    checks++; if (lat !== 3 || q !== 8'h5A) begin errors++; $display("FAIL rr_lone_req3: got %0d/%h expected 3/5a", lat, q); end
  endtask

  task automatic test_drop_after_grant();
    int lat; logic e; logic [NREQ-1:0] g;
    run_op(1, M_T, 8'hFF, 8'h00, 1'b1, lat, e, g);
    checks++; if (lat !== 3 || g !== 4'b0010) begin errors++; $display("FAIL drop_lat_gnt: got %0d/%b expected 3/0010", lat, g); end
    checks++; if (q !== 8'hA5) begin errors++; $display("FAIL drop_q: got %h expected a5", q); end
  endtask

  task automatic test_reset_mid_op();
    int lat; logic e; logic [NREQ-1:0] g; logic bad;
    @(posedge clk); #1;
    mode[1:0] = M_D; a[7:0] = 8'h77; req[0] = 1'b1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    checks++; if (busy !== 1'b1 || gnt !== 4'b0001) begin errors++; $display("FAIL rstmid_apply: busy %b gnt %b expected 1 0001", busy, gnt); end
    rst = 1'b0;
    #1;
    checks++; if (q !== 8'h00 || qb !== 8'hFF) begin errors++; $display("FAIL rstmid_q: got %h/%h expected 00/ff", q, qb); end
    checks++; if (gnt !== 4'h0 || busy !== 1'b0) begin errors++; $display("FAIL rstmid_ctrl: gnt %h busy %b expected 0 0", gnt, busy); end
    req[0] = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;
    bad = 1'b0;
    for (int k = 0; k < 4; k++) begin
      @(posedge clk); #1;
      if (ack !== 4'h0 || q !== 8'h00) bad = 1'b1;
    end
    checks++; if (bad !== 1'b0) begin errors++; $display("FAIL rstmid_no_ack: saw ack or q change, expected none"); end
    run_op(1, M_D, 8'h3C, 8'h00, 1'b0, lat, e, g);
    checks++; if (lat !== 3 || q !== 8'h3C) begin errors++; $display("FAIL rstmid_recover: got %0d/%h expected 3/3c", lat, q); end
  endtask

  initial begin
    test_reset();
    test_idle();
    test_d_then_t();
    test_jk();
    test_sr_illegal();
    test_round_robin();
    test_drop_after_grant();
    test_reset_mid_op();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
